dsram_req_ctrl: RTL

Sequencer for the CPU's data-memory port. It takes one load/store request per transaction from the execute stage and drives it onto the SRAM-like data bus (req / addr_ok / data_ok). It buffers the response until the memory stage consumes it, and discards in-flight responses on a pipeline flush. It sits between the EXE/MEM stage pair and the data-side bus, and replaces the direct data_sram connection.

---
 rtl/dsram_req_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dsram_req_ctrl.sv
// dsram_req_ctrl: single-outstanding sequencer between the EXE/MEM stages and
// an SRAM-like data bus (req / addr_ok / data_ok).
// Optional build macro: DSRAM_FLUSH_EN enables flush handling and the discard
// flag. Without it the flush port is ignored and every accepted request
// produces exactly one buffered response.
// Bus protocol violations (data_data_ok outside RESP, data_addr_ok outside REQ)
// are ignored by construction: every transition is qualified by the state.

module dsram_req_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        es_req_valid,
  input  logic        es_req_wr,
  input  logic [1:0]  es_req_size,
  input  logic [3:0]  es_req_wstrb,
  input  logic [31:0] es_req_addr,
  input  logic [31:0] es_req_wdata,
  output logic        es_req_ready,
  output logic        ms_resp_valid,
  output logic        ms_resp_wr,
  output logic [31:0] ms_rdata,
  input  logic        ms_resp_take,
  input  logic        flush,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic [31:0] data_rdata,
  input  logic        data_data_ok
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t state_reg;
  state_t state_next;
  logic   discard_reg;
  logic   discard_next;
  logic   flush_eff;
  logic   accept;
  logic   capture;
  logic   data_req_next;
  logic   ms_resp_valid_next;

`ifdef DSRAM_FLUSH_EN
  assign flush_eff = flush;
`else
  // Flush is architecturally ignored in this build; keep the port visibly sunk.
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_eff    = 1'b0;
`endif

  // State register and discard flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      discard_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      discard_reg <= discard_next;
    end
  end

  // Next-state logic, including flush kill and discard of in-flight responses.
  always_comb begin
    state_next   = state_reg;
    discard_next = discard_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) state_next = S_REQ;
      end
      S_REQ: begin
        if (flush_eff) begin
          // Accepted in the same cycle: the slave owes us a beat we must swallow.
          if (data_addr_ok) begin
            state_next   = S_RESP;
            discard_next = 1'b1;
          end else begin
            state_next   = S_IDLE;
          end
        end else if (data_addr_ok) begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (flush_eff) begin
          // A beat arriving with the flush itself is simply dropped.
          if (data_data_ok) begin
            state_next   = S_IDLE;
            discard_next = 1'b0;
          end else begin
            discard_next = 1'b1;
          end
        end else if (data_data_ok) begin
          state_next   = discard_reg ? S_IDLE : S_HOLD;
          discard_next = 1'b0;
        end
      end
      S_HOLD: begin
        if (flush_eff || ms_resp_take) state_next = S_IDLE;
      end
      default: begin
        state_next   = S_IDLE;
        discard_next = 1'b0;
      end
    endcase
  end

  // Output decode: handshake is combinational, bus/response strobes are
  // precomputed from the next state so they come straight out of flops.
  always_comb begin
    es_req_ready       = (state_reg == S_IDLE) && !flush_eff;
    accept             = es_req_valid && es_req_ready;
    capture            = (state_reg == S_RESP) && data_data_ok &&
                         !discard_reg && !flush_eff;
    data_req_next      = (state_next == S_REQ);
    ms_resp_valid_next = (state_next == S_HOLD);
  end

  // Request register; it drives the bus fields directly so they stay stable
  // for the whole REQ phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_wstrb <= 4'd0;
      data_addr  <= 32'd0;
      data_wdata <= 32'd0;
    end else if (accept) begin
      data_wr    <= es_req_wr;
      data_size  <= es_req_size;
      data_wstrb <= es_req_wstrb;
      data_addr  <= es_req_addr;
      data_wdata <= es_req_wdata;
    end
  end

  // Registered strobes and the response buffer held for the MEM stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_req      <= 1'b0;
      ms_resp_valid <= 1'b0;
      ms_resp_wr    <= 1'b0;
      ms_rdata      <= 32'd0;
    end else begin
      data_req      <= data_req_next;
      ms_resp_valid <= ms_resp_valid_next;
      if (capture) begin
        ms_rdata   <= data_rdata;
        ms_resp_wr <= data_wr;
      end
    end
  end

endmodule
